// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL-style encoder/decoder family.
//   NUM_LINES / VEC_W : request line count and encoded vector width
//   state_t           : arbitration FSM states
//   prio_enc8         : {valid, index} of the highest set bit of an 8-bit word
package ttl_pkg;

  localparam int NUM_LINES = 8;
  localparam int VEC_W     = 3;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // Bit 7 has the highest priority; MSB of the result is the valid flag.
  function automatic logic [VEC_W:0] prio_enc8(input logic [NUM_LINES-1:0] v);
    logic [VEC_W:0] r;
    casez (v)
      8'b1???????: r = 4'b1_111;
      8'b01??????: r = 4'b1_110;
      8'b001?????: r = 4'b1_101;
      8'b0001????: r = 4'b1_100;
      8'b00001???: r = 4'b1_011;
      8'b000001??: r = 4'b1_010;
      8'b0000001?: r = 4'b1_001;
      8'b00000001: r = 4'b1_000;
      default:     r = 4'b0_000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ttl_sync2.sv
// Generic two-flop synchroniser.
//   clk   : destination clock
//   rst   : asynchronous active-high reset, loads RST_VAL into both stages
//   i_d   : asynchronous input, W bits
//   o_q   : synchronised output, W bits
module ttl_sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/irq_priority_encoder.sv
// Eight-line priority interrupt encoder with in-service tracking and
// 74148-style cascade outputs.
//   clk, rst : clock, asynchronous active-high reset
//   R_n      : active-low asynchronous request lines
//   EI_n     : active-low enable; high blocks new arbitration
//   MASK_WE  : mask write strobe, MASK_D : mask data (1 masks a line)
//   ACK      : CPU acknowledge of the presented vector
//   EOI      : end-of-interrupt, clears the highest in-service level
//   A        : registered vector, INT_n : registered active-low request
//   GS_n     : low when enabled and any unmasked request is active
//   EO_n     : low when enabled and no unmasked request is active
//   ISR      : in-service register
module irq_priority_encoder
  import ttl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] R_n,
  input  logic                 EI_n,
  input  logic                 MASK_WE,
  input  logic [NUM_LINES-1:0] MASK_D,
  input  logic                 ACK,
  input  logic                 EOI,
  output logic [VEC_W-1:0]     A,
  output logic                 INT_n,
  output logic                 GS_n,
  output logic                 EO_n,
  output logic [NUM_LINES-1:0] ISR
);

  logic [NUM_LINES-1:0] w_rn_sync;
  logic [NUM_LINES-1:0] w_req;
  logic [VEC_W:0]       w_win;
  logic [VEC_W:0]       w_top;
  logic                 w_elig;
  state_t               w_state_nxt;
  logic [VEC_W-1:0]     w_a_nxt;
  logic [NUM_LINES-1:0] w_isr_nxt;

  state_t               r_state;
  logic [VEC_W-1:0]     r_a;
  logic                 r_int_n;
  logic                 r_gs_n;
  logic                 r_eo_n;
  logic [NUM_LINES-1:0] r_mask;
  logic [NUM_LINES-1:0] r_isr;

  // Idle request level is high, so synchronisers reset to all ones.
  ttl_sync2 #(
    .W       (NUM_LINES),
    .RST_VAL ({NUM_LINES{1'b1}})
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (R_n),
    .o_q (w_rn_sync)
  );

  assign w_req = ~w_rn_sync & ~r_mask;
  assign w_win = prio_enc8(w_req);
  assign w_top = prio_enc8(r_isr);

  // Only strictly higher levels may nest above the current in-service level.
  assign w_elig = !EI_n && w_win[VEC_W] &&
                  (!w_top[VEC_W] || (w_win[VEC_W-1:0] > w_top[VEC_W-1:0]));

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    unique case (r_state)
      IDLE: begin
        if (w_elig) begin
          w_state_nxt = PEND;
          w_a_nxt     = w_win[VEC_W-1:0];
        end
      end
      PEND: begin
        // A latched vector is always delivered; only ACK leaves this state.
        if (ACK) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // EOI acts on the old top level before ACK adds the new one.
  always_comb begin
    w_isr_nxt = r_isr;
    if (EOI && w_top[VEC_W]) w_isr_nxt[w_top[VEC_W-1:0]] = 1'b0;
    if ((r_state == PEND) && ACK) w_isr_nxt[r_a] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_int_n <= 1'b1;
      r_gs_n  <= 1'b1;
      r_eo_n  <= 1'b1;
      r_mask  <= '0;
      r_isr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_int_n <= (w_state_nxt != PEND);
      r_gs_n  <= !(!EI_n && (|w_req));
      r_eo_n  <= !(!EI_n && !(|w_req));
      if (MASK_WE) r_mask <= MASK_D;
      r_isr   <= w_isr_nxt;
    end
  end

  assign A     = r_a;
  assign INT_n = r_int_n;
  assign GS_n  = r_gs_n;
  assign EO_n  = r_eo_n;
  assign ISR   = r_isr;

endmodule

// File: tb/tb_irq_priority_encoder.sv
module tb_irq_priority_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] R_n;
  logic       EI_n;
  logic       MASK_WE;
  logic [7:0] MASK_D;
  logic       ACK;
  logic       EOI;
  logic [2:0] A;
  logic       INT_n;
  logic       GS_n;
  logic       EO_n;
  logic [7:0] ISR;

  always #5 clk = ~clk;

  irq_priority_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .R_n     (R_n),
    .EI_n    (EI_n),
    .MASK_WE (MASK_WE),
    .MASK_D  (MASK_D),
    .ACK     (ACK),
    .EOI     (EOI),
    .A       (A),
    .INT_n   (INT_n),
    .GS_n    (GS_n),
    .EO_n    (EO_n),
    .ISR     (ISR)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: R_n samples seen at the last two edges,
  // the mask, whether a vector is pending, and the visible outputs.
  logic [7:0] rn_seen [2];
  logic [7:0] m_mask;
  bit         m_pend;
  int         m_a;
  logic [7:0] m_isr;
  bit         m_gs_n;
  bit         m_eo_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    rn_seen[0] = 8'hFF;
    rn_seen[1] = 8'hFF;
    m_mask = 8'h00;
    m_pend = 0;
    m_a    = 0;
    m_isr  = 8'h00;
    m_gs_n = 1;
    m_eo_n = 1;
  endtask

  task automatic compare_all(input string where);
    check({where, ".A"},     {29'd0, A},     m_a);
    check({where, ".INT_n"}, {31'd0, INT_n}, {31'd0, !m_pend});
    check({where, ".GS_n"},  {31'd0, GS_n},  {31'd0, m_gs_n});
    check({where, ".EO_n"},  {31'd0, EO_n},  {31'd0, m_eo_n});
    check({where, ".ISR"},   {24'd0, ISR},   {24'd0, m_isr});
  endtask

  // Advance one clock: update the model from the inputs the DUT sees at
  // this edge, then compare a little after the edge.
  task automatic step(input string where);
    logic [7:0] req, isr_n;
    int w, t;
    bit pend_n;
    int a_n;
    req = ~rn_seen[1] & ~m_mask;
    w = highest(req);
    t = highest(m_isr);
    isr_n  = m_isr;
    pend_n = m_pend;
    a_n    = m_a;
    if (EOI && t >= 0) isr_n[t] = 1'b0;
    if (m_pend && ACK) begin
      isr_n[m_a] = 1'b1;
      pend_n = 0;
    end
    if (!m_pend && !EI_n && w >= 0 && (t < 0 || w > t)) begin
      pend_n = 1;
      a_n    = w;
    end
    @(posedge clk);
    m_gs_n = !(!EI_n && req != 0);
    m_eo_n = !(!EI_n && req == 0);
    m_isr  = isr_n;
    m_pend = pend_n;
    m_a    = a_n;
    if (MASK_WE) m_mask = MASK_D;
    rn_seen[1] = rn_seen[0];
    rn_seen[0] = R_n;
    #1;
    compare_all(where);
  endtask

  task automatic steps(input string where, input int n);
    for (int i = 0; i < n; i++) step(where);
  endtask

  task automatic pulse_ack(input string where);
    ACK = 1; step(where); ACK = 0;
  endtask

  task automatic pulse_eoi(input string where);
    EOI = 1; step(where); EOI = 0;
  endtask

  task automatic do_reset(input logic [7:0] rn);
    rst = 1; R_n = rn;
    EI_n = 0; MASK_WE = 0; MASK_D = 8'h00; ACK = 0; EOI = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    compare_all("reset");
    rst = 0;
  endtask

  initial begin
    do_reset(8'h00);
    check("rst_A", {29'd0, A}, 32'd0);
    check("rst_INT_n", {31'd0, INT_n}, 32'd1);
    check("rst_ISR", {24'd0, ISR}, 32'd0);

    // Idle lines: EO_n low after three edges.
    R_n = 8'hFF; EI_n = 0;
    steps("idle", 3);
    check("idle_EO_n", {31'd0, EO_n}, 32'd0);

    // Basic arbitration: lines 5 and 2.
    R_n = 8'b1101_1011;
    steps("basic", 3);
    check("basic_INT_n", {31'd0, INT_n}, 32'd0);
    check("basic_A", {29'd0, A}, 32'd5);
    check("basic_GS_n", {31'd0, GS_n}, 32'd0);
    pulse_ack("basic_ack");
    check("basic_ISR", {24'd0, ISR}, 32'h20);

    // Nesting: line 2 blocked below level 5, line 7 nests.
    R_n = 8'hFB;
    steps("nest_lo", 4);
    check("nest_lo_INT_n", {31'd0, INT_n}, 32'd1);
    R_n = 8'h7B;
    steps("nest_hi", 3);
    check("nest_hi_A", {29'd0, A}, 32'd7);
    pulse_ack("nest_ack");
    check("nest_ISR", {24'd0, ISR}, 32'hA0);
    R_n = 8'hFB;
    steps("nest_rel", 3);
    pulse_eoi("nest_eoi1");
    check("nest_eoi1_ISR", {24'd0, ISR}, 32'h20);
    pulse_eoi("nest_eoi2");
    check("nest_eoi2_ISR", {24'd0, ISR}, 32'h00);
    step("nest_l2");
    check("nest_l2_A", {29'd0, A}, 32'd2);
    check("nest_l2_INT_n", {31'd0, INT_n}, 32'd0);

    // Mask line 5 so line 2 wins; mask write during PEND keeps A.
    do_reset(8'hDB);
    MASK_WE = 1; MASK_D = 8'h20;
    step("mask_wr");
    MASK_WE = 0;
    steps("mask", 3);
    check("mask_A", {29'd0, A}, 32'd2);
    MASK_WE = 1; MASK_D = 8'h04;
    step("mask_pend");
    MASK_WE = 0;
    steps("mask_pend", 3);
    check("mask_pend_A", {29'd0, A}, 32'd2);
    check("mask_pend_INT_n", {31'd0, INT_n}, 32'd0);

    // Enable gating.
    do_reset(8'h00);
    EI_n = 1;
    steps("en_off", 4);
    check("en_off_INT_n", {31'd0, INT_n}, 32'd1);
    check("en_off_GS_n", {31'd0, GS_n}, 32'd1);
    check("en_off_EO_n", {31'd0, EO_n}, 32'd1);
    EI_n = 0;
    step("en_on");
    check("en_on_INT_n", {31'd0, INT_n}, 32'd0);
    check("en_on_A", {29'd0, A}, 32'd7);

    // Simultaneous ACK and EOI.
    do_reset(8'hDF);
    steps("sim_l5", 3);
    pulse_ack("sim_ack5");
    R_n = 8'h7F;
    steps("sim_l7", 3);
    check("sim_l7_A", {29'd0, A}, 32'd7);
    ACK = 1; EOI = 1;
    step("sim_both");
    ACK = 0; EOI = 0;
    check("sim_both_ISR", {24'd0, ISR}, 32'h80);
    pulse_eoi("sim_eoi");
    steps("sim_re7", 2);
    check("sim_re7_INT_n", {31'd0, INT_n}, 32'd0);

    // Asynchronous reset mid-PEND, checked between clock edges.
    #2; rst = 1; #1;
    check("arst_INT_n", {31'd0, INT_n}, 32'd1);
    check("arst_ISR", {24'd0, ISR}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    R_n = 8'hFF;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      R_n     = 8'($urandom);
      if ($urandom_range(3) == 0) R_n = 8'hFF;
      EI_n    = ($urandom_range(9) == 0);
      MASK_WE = ($urandom_range(15) == 0);
      MASK_D  = 8'($urandom) & 8'($urandom);
      ACK     = ($urandom_range(2) == 0);
      EOI     = ($urandom_range(5) == 0);
      step("rand");
    end
    ACK = 0; EOI = 0; MASK_WE = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
